// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: two-stage valid/ready pipelined 4-bit add/subtract unit.
// Stage S1 captures the operand bundle, a 4-bit carry-lookahead adder sits
// between S1 and S2, and S2 holds the registered result and status flags.
// Subtraction is performed as a + ~b + !borrow_in, so the same lookahead
// adder serves both operations; the carry-out is inverted to form a borrow.
module cla_sub_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       op,
  input  logic       cbin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] res,
  output logic       cbout,
  output logic       of,
  output logic       zero
);

  // 4-bit carry-lookahead adder: returns {carry out of bit 3, carry into bit 3, sum}.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], c[3], p ^ c[3:0]};
  endfunction

  // Stage S1 state
  logic       s1_valid_r;
  logic [3:0] s1_a_r;
  logic [3:0] s1_b_r;
  logic       s1_op_r;
  logic       s1_cbin_r;

  // Stage S2 state (drives the outputs directly)
  logic       s2_valid_r;
  logic [3:0] res_r;
  logic       cbout_r;
  logic       of_r;
  logic       zero_r;

  // Handshake and datapath signals
  logic       accept_s;
  logic       s2_load_s;
  logic       drain_s;
  logic [3:0] add_b_s;
  logic       add_cin_s;
  logic [5:0] cla_out_s;
  logic [3:0] sum_s;
  logic       c3_s;
  logic       c4_s;
  logic       cbout_s;
  logic       of_s;
  logic       zero_s;

  // Ready depends only on stage occupancy and the consumer, never on in_valid.
  assign in_ready  = !s1_valid_r || !s2_valid_r || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign drain_s   = s2_valid_r && out_ready;
  // S1 moves into S2 when S2 is empty or is handing its result off this cycle.
  assign s2_load_s = s1_valid_r && (!s2_valid_r || out_ready);

  assign out_valid = s2_valid_r;
  assign res       = res_r;
  assign cbout     = cbout_r;
  assign of        = of_r;
  assign zero      = zero_r;

  // Select adder operands: invert b and the borrow-in for subtraction.
  always_comb begin
    add_b_s   = s1_b_r;
    add_cin_s = s1_cbin_r;
    if (s1_op_r) begin
      add_b_s   = ~s1_b_r;
      add_cin_s = ~s1_cbin_r;
    end else begin
      add_b_s   = s1_b_r;
      add_cin_s = s1_cbin_r;
    end
  end

  // Lookahead addition and derivation of the status flags.
  always_comb begin
    cla_out_s = cla4(s1_a_r, add_b_s, add_cin_s);
    c4_s      = cla_out_s[5];
    c3_s      = cla_out_s[4];
    sum_s     = cla_out_s[3:0];
    of_s      = c3_s ^ c4_s;
    zero_s    = (sum_s == 4'b0000);
    if (s1_op_r) begin
      cbout_s = ~c4_s;
    end else begin
      cbout_s = c4_s;
    end
  end

  // S1 occupancy: set on accept, cleared when the bundle moves on to S2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // S1 operand capture; operands are ignored unless a transfer happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_a_r    <= 4'b0000;
      s1_b_r    <= 4'b0000;
      s1_op_r   <= 1'b0;
      s1_cbin_r <= 1'b0;
    end else if (accept_s) begin
      s1_a_r    <= a;
      s1_b_r    <= b;
      s1_op_r   <= op;
      s1_cbin_r <= cbin;
    end else begin
      s1_a_r    <= s1_a_r;
      s1_b_r    <= s1_b_r;
      s1_op_r   <= s1_op_r;
      s1_cbin_r <= s1_cbin_r;
    end
  end

  // S2 occupancy: set when loaded from S1, cleared when drained with nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= 1'b1;
    end else if (drain_s) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // S2 result registers: only change on a load, so they hold through stalls and idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_r   <= 4'b0000;
      cbout_r <= 1'b0;
      of_r    <= 1'b0;
      zero_r  <= 1'b1;
    end else if (s2_load_s) begin
      res_r   <= sum_s;
      cbout_r <= cbout_s;
      of_r    <= of_s;
      zero_r  <= zero_s;
    end else begin
      res_r   <= res_r;
      cbout_r <= cbout_r;
      of_r    <= of_r;
      zero_r  <= zero_r;
    end
  end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Self-checking bench for cla_sub_pipe: directed scenarios plus a randomized
// run scored against an arithmetic reference model and an in-order queue.
module tb_cla_sub_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       op;
  logic       cbin;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] res;
  logic       cbout;
  logic       of;
  logic       zero;

  int checks = 0;
  int errors = 0;

  cla_sub_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cbin      (cbin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .cbout     (cbout),
    .of        (of),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {res, cbout, of, zero}.
  function automatic logic [6:0] ref_model(input logic [3:0] av, input logic [3:0] bv,
                                           input logic opv, input logic cv);
    int ua, ub, sa, sb, u, s, ci;
    logic [3:0] r;
    logic co, ov;
    ua = int'(av);
    ub = int'(bv);
    ci = cv ? 1 : 0;
    sa = av[3] ? ua - 16 : ua;
    sb = bv[3] ? ub - 16 : ub;
    if (!opv) begin
      u  = ua + ub + ci;
      s  = sa + sb + ci;
      co = (u > 15);
    end else begin
      u  = ua - ub - ci;
      s  = sa - sb - ci;
      co = (u < 0);
    end
    r  = u[3:0];
    ov = (s > 7) || (s < -8);
    return {r, co, ov, (r == 4'd0)};
  endfunction

  task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv,
                       input logic opv, input logic cv);
    in_valid = v;
    a        = av;
    b        = bv;
    op       = opv;
    cbin     = cv;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    #2;
    checks++;
    if ({out_valid, res, cbout, of, zero} !== 8'b0_0000_001) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b", {out_valid, res, cbout, of, zero}, 8'b0_0000_001);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_latency;
    out_ready = 1'b1;
    drive(1'b1, 4'b0101, 4'b0111, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_early got out_valid=%b want=0", out_valid);
    end
    tick();
    checks++;
    if ({out_valid, res, cbout, of, zero} !== 8'b1_1100_010) begin
      errors++;
      $display("FAIL add_0101_0111 got=%b want=%b", {out_valid, res, cbout, of, zero}, 8'b1_1100_010);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drained got out_valid=%b want=0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    drive(1'b1, 4'b1000, 4'b0111, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b0101, 4'b0001, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checks++;
    if ({out_valid, res, cbout, of} !== 7'b1_1111_00) begin
      errors++;
      $display("FAIL b2b_first got=%b want=%b", {out_valid, res, cbout, of}, 7'b1_1111_00);
    end
    tick();
    checks++;
    if ({out_valid, res, cbout, of, zero} !== 8'b1_0110_000) begin
      errors++;
      $display("FAIL b2b_second got=%b want=%b", {out_valid, res, cbout, of, zero}, 8'b1_0110_000);
    end
    tick();
  endtask

  task automatic test_sub;
    out_ready = 1'b1;
    drive(1'b1, 4'b0001, 4'b0010, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'b1000, 4'b0001, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'b0011, 4'b0011, 1'b1, 1'b0);
    checks++;
    if ({out_valid, res, cbout, of, zero} !== 8'b1_1111_100) begin
      errors++;
      $display("FAIL sub_1_2 got=%b want=%b", {out_valid, res, cbout, of, zero}, 8'b1_1111_100);
    end
    tick();
    drive(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1);
    checks++;
    if ({out_valid, res, cbout, of, zero} !== 8'b1_0111_010) begin
      errors++;
      $display("FAIL sub_8_1 got=%b want=%b", {out_valid, res, cbout, of, zero}, 8'b1_0111_010);
    end
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checks++;
    if ({out_valid, res, cbout, of, zero} !== 8'b1_0000_001) begin
      errors++;
      $display("FAIL sub_3_3 got=%b want=%b", {out_valid, res, cbout, of, zero}, 8'b1_0000_001);
    end
    tick();
    // 0 - 0 - borrow_in = 1111 with borrow out
    checks++;
    if ({out_valid, res, cbout, of, zero} !== 8'b1_1111_100) begin
      errors++;
      $display("FAIL sub_borrow_in got=%b want=%b", {out_valid, res, cbout, of, zero}, 8'b1_1111_100);
    end
    tick();
  endtask

  task automatic test_stall;
    logic [6:0] e1, e2, e3;
    e1 = ref_model(4'd3, 4'd4, 1'b0, 1'b1);
    e2 = ref_model(4'd9, 4'd2, 1'b1, 1'b0);
    e3 = ref_model(4'd15, 4'd15, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, 4'd3, 4'd4, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'd9, 4'd2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd15, 4'd15, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_ready got=%b want=0", in_ready);
    end
    checks++;
    if ({out_valid, res, cbout, of, zero} !== {1'b1, e1}) begin
      errors++;
      $display("FAIL stall_head got=%b want=%b", {out_valid, res, cbout, of, zero}, {1'b1, e1});
    end
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, res, cbout, of, zero} !== {2'b01, e1}) begin
      errors++;
      $display("FAIL stall_hold got=%b want=%b", {in_ready, out_valid, res, cbout, of, zero}, {2'b01, e1});
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready got=%b want=1", in_ready);
    end
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checks++;
    if ({out_valid, res, cbout, of, zero} !== {1'b1, e2}) begin
      errors++;
      $display("FAIL stall_drain2 got=%b want=%b", {out_valid, res, cbout, of, zero}, {1'b1, e2});
    end
    tick();
    checks++;
    if ({out_valid, res, cbout, of, zero} !== {1'b1, e3}) begin
      errors++;
      $display("FAIL stall_drain3 got=%b want=%b", {out_valid, res, cbout, of, zero}, {1'b1, e3});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty got out_valid=%b want=0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    logic [6:0] e;
    out_ready = 1'b0;
    drive(1'b1, 4'd6, 4'd6, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd7, 4'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, res, cbout, of, zero, in_ready} !== 9'b0_0000_0011) begin
      errors++;
      $display("FAIL mid_reset got=%b want=%b", {out_valid, res, cbout, of, zero, in_ready}, 9'b0_0000_0011);
    end
    #3;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_ghost cycle=%0d got out_valid=%b want=0", i, out_valid);
      end
    end
    e = ref_model(4'd10, 4'd12, 1'b1, 1'b1);
    drive(1'b1, 4'd10, 4'd12, 1'b1, 1'b1);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({out_valid, res, cbout, of, zero} !== {1'b1, e}) begin
      errors++;
      $display("FAIL mid_reset_new got=%b want=%b", {out_valid, res, cbout, of, zero}, {1'b1, e});
    end
    tick();
  endtask

  task automatic test_random;
    logic [6:0] q[$];
    logic [6:0] e;
    int accepted = 0;
    int got = 0;
    int cyc = 0;
    logic acc, drn, exp_rdy;
    while (accepted < 1000 && cyc < 20000) begin
      drive(($urandom % 4) != 0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      out_ready = ($urandom % 4) != 0;
      #2;
      exp_rdy = (q.size() < 2) || out_ready;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rand_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_rdy);
      end
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious cyc=%0d got out_valid=1 want no pending result", cyc);
        end else if ({res, cbout, of, zero} !== q[0]) begin
          errors++;
          $display("FAIL rand_result cyc=%0d got=%b want=%b", cyc, {res, cbout, of, zero}, q[0]);
        end
      end
      if (drn && q.size() != 0) begin
        e = q.pop_front();
        got++;
      end
      if (acc) begin
        q.push_back(ref_model(a, b, op, cbin));
        accepted++;
      end
      tick();
      cyc++;
    end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_tail_spurious got out_valid=1 want no pending result");
        end else if ({res, cbout, of, zero} !== q[0]) begin
          errors++;
          $display("FAIL rand_tail_result got=%b want=%b", {res, cbout, of, zero}, q[0]);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          got++;
        end
      end
      tick();
    end
    checks++;
    if (accepted != 1000) begin
      errors++;
      $display("FAIL rand_timeout got accepted=%0d want=1000", accepted);
    end
    checks++;
    if (got != accepted || q.size() != 0) begin
      errors++;
      $display("FAIL rand_count got results=%0d want=%0d (left %0d)", got, accepted, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_sub();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
